// File: rtl/mux_scan_sequencer_pkg.sv
// rtl/mux_scan_sequencer_pkg.sv - shared types and constants for the mux scan sequencer
package mux_scan_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

endpackage

// File: rtl/mux_settle_timer.sv
// rtl/mux_settle_timer.sv - settle counter that pulses done after SETTLE_CYC enabled cycles
module mux_settle_timer #(
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  // The compare value is truncated to the counter width; the check below
  // guarantees the truncation never loses information.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYC - 1);

  if (SETTLE_CYC < 1 || SETTLE_CYC >= (1 << CNT_W)) begin : g_bad_param
    $error("mux_settle_timer: SETTLE_CYC must be in 1..2**CNT_W-1");
  end

  logic [CNT_W-1:0] cnt;

  assign done = enable && (cnt == LAST);

  // Count enabled cycles; wrap to zero on done so the next channel starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || done) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps a 4:1 mux through all channels and packs the samples into a word
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       e,
  output logic       s1,
  output logic       s2,
  output logic       busy,
  output logic [3:0] word_out,
  output logic       word_valid,
  input  logic       word_ready
);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [NUM_CH-1:0]   shadow_q, shadow_d;
  logic [NUM_CH-1:0]   word_q, word_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                settle_done;

  // The counter only runs while scanning, so every scan entry sees it at zero.
  mux_settle_timer #(
    .SETTLE_CYC (SETTLE_CYC),
    .CNT_W      (CNT_W)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q != SCAN),
    .enable (state_q == SCAN),
    .done   (settle_done)
  );

  // State and datapath registers; reset discards any in-flight scan immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sel_q    <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic: start only in IDLE, capture on settle done, release on handshake.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    valid_d  = valid_q;
    busy_d   = busy_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          idx_d   = '0;
          sel_d   = '0;
          busy_d  = 1'b1;
        end
      end

      SCAN: begin
        if (settle_done) begin
          shadow_d[idx_q] = e;
          if (idx_q != SEL_W'(NUM_CH - 1)) begin
            idx_d = idx_q + SEL_W'(1);
            sel_d = idx_q + SEL_W'(1);
          end else begin
            // Last channel bypasses the shadow so the word is complete on this edge.
            state_d = HOLD;
            word_d  = {e, shadow_q[NUM_CH-2:0]};
            valid_d = 1'b1;
          end
        end
      end

      HOLD: begin
        if (valid_q && word_ready) begin
          valid_d = 1'b0;
          idx_d   = '0;
          sel_d   = '0;
          if (cont) begin
            state_d = SCAN;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s1         = sel_q[1];
  assign s2         = sel_q[0];
  assign busy       = busy_q;
  assign word_out   = word_q;
  assign word_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - directed self-checking bench for mux_scan_sequencer
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic a, b, c, d;
  logic cont, word_ready;
  logic start1, start3;

  logic s1_1, s2_1, busy_1, valid_1;
  logic [3:0] word_1;
  logic s1_3, s2_3, busy_3, valid_3;
  logic [3:0] word_3;
  logic [3:0] src;
  logic e1, e3;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // The 1-bit 4:1 mux each sequencer drives.
  assign src = {d, c, b, a};
  assign e1  = src[{s1_1, s2_1}];
  assign e3  = src[{s1_3, s2_3}];

  mux_scan_sequencer #(.SETTLE_CYC(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont), .e(e1),
    .s1(s1_1), .s2(s2_1), .busy(busy_1), .word_out(word_1),
    .word_valid(valid_1), .word_ready(word_ready)
  );

  mux_scan_sequencer #(.SETTLE_CYC(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .cont(cont), .e(e3),
    .s1(s1_3), .s2(s2_3), .busy(busy_3), .word_out(word_3),
    .word_valid(valid_3), .word_ready(word_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start1 = 0; start3 = 0; cont = 0; word_ready = 0;
    a = 0; b = 0; c = 0; d = 0;
    step();
    step();
    total_cnt++;
    if ({s1_1, s2_1, busy_1, valid_1, word_1} !== 8'h00)
      $display("FAIL reset_dut1 got=%b exp=00000000", {s1_1, s2_1, busy_1, valid_1, word_1});
    else pass_cnt++;
    total_cnt++;
    if ({s1_3, s2_3, busy_3, valid_3, word_3} !== 8'h00)
      $display("FAIL reset_dut3 got=%b exp=00000000", {s1_3, s2_3, busy_3, valid_3, word_3});
    else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_scan();
    a = 0; b = 1; c = 0; d = 1; word_ready = 1; cont = 0;
    start1 = 1;
    step();
    start1 = 0;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if ({s1_1, s2_1} !== 2'(k) || valid_1 !== 1'b0 || busy_1 !== 1'b1)
        $display("FAIL basic_sel k=%0d sel=%b valid=%b busy=%b exp sel=%b valid=0 busy=1",
                 k, {s1_1, s2_1}, valid_1, busy_1, 2'(k));
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (valid_1 !== 1'b1 || word_1 !== 4'b1010 || busy_1 !== 1'b1)
      $display("FAIL basic_word valid=%b word=%b busy=%b exp valid=1 word=1010 busy=1",
               valid_1, word_1, busy_1);
    else pass_cnt++;
    step();
    total_cnt++;
    if (valid_1 !== 1'b0 || busy_1 !== 1'b0 || {s1_1, s2_1} !== 2'b00)
      $display("FAIL basic_release valid=%b busy=%b sel=%b exp 0 0 00",
               valid_1, busy_1, {s1_1, s2_1});
    else pass_cnt++;
  endtask

  task automatic test_settle3();
    a = 0; b = 1; c = 0; d = 1; word_ready = 1; cont = 0;
    start3 = 1;
    step();
    start3 = 0;
    for (int k = 0; k < 12; k++) begin
      total_cnt++;
      if ({s1_3, s2_3} !== 2'(k / 3) || valid_3 !== 1'b0)
        $display("FAIL settle3_sel k=%0d sel=%b valid=%b exp sel=%b valid=0",
                 k, {s1_3, s2_3}, valid_3, 2'(k / 3));
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (valid_3 !== 1'b1 || word_3 !== 4'b1010)
      $display("FAIL settle3_word valid=%b word=%b exp valid=1 word=1010", valid_3, word_3);
    else pass_cnt++;
    step();
    total_cnt++;
    if (valid_3 !== 1'b0 || busy_3 !== 1'b0)
      $display("FAIL settle3_release valid=%b busy=%b exp 0 0", valid_3, busy_3);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    a = 1; b = 1; c = 0; d = 0; word_ready = 0; cont = 0;
    start1 = 1;
    step();
    start1 = 0;
    repeat (4) step();
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (valid_1 !== 1'b1 || word_1 !== 4'b0011 || busy_1 !== 1'b1)
        $display("FAIL hold_stable i=%0d valid=%b word=%b busy=%b exp 1 0011 1",
                 i, valid_1, word_1, busy_1);
      else pass_cnt++;
      start1 = (i == 2);
      step();
    end
    start1 = 0;
    word_ready = 1;
    step();
    total_cnt++;
    if (valid_1 !== 1'b0 || busy_1 !== 1'b0 || word_1 !== 4'b0011)
      $display("FAIL hold_release valid=%b busy=%b word=%b exp 0 0 0011", valid_1, busy_1, word_1);
    else pass_cnt++;
    word_ready = 0;
    step();
    total_cnt++;
    if (busy_1 !== 1'b0 || {s1_1, s2_1} !== 2'b00)
      $display("FAIL hold_start_not_queued busy=%b sel=%b exp 0 00", busy_1, {s1_1, s2_1});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    a = 0; b = 1; c = 0; d = 1; word_ready = 1; cont = 1;
    start1 = 1;
    step();
    start1 = 0;
    repeat (4) step();
    total_cnt++;
    if (valid_1 !== 1'b1 || word_1 !== 4'b1010)
      $display("FAIL b2b_word1 valid=%b word=%b exp 1 1010", valid_1, word_1);
    else pass_cnt++;
    a = 1; b = 0; c = 1; d = 1;
    step();
    total_cnt++;
    if (valid_1 !== 1'b0 || busy_1 !== 1'b1 || {s1_1, s2_1} !== 2'b00)
      $display("FAIL b2b_restart valid=%b busy=%b sel=%b exp 0 1 00", valid_1, busy_1, {s1_1, s2_1});
    else pass_cnt++;
    for (int k = 1; k < 4; k++) begin
      step();
      total_cnt++;
      if (busy_1 !== 1'b1 || {s1_1, s2_1} !== 2'(k))
        $display("FAIL b2b_scan k=%0d busy=%b sel=%b exp 1 %b", k, busy_1, {s1_1, s2_1}, 2'(k));
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if (valid_1 !== 1'b1 || word_1 !== 4'b1101 || busy_1 !== 1'b1)
      $display("FAIL b2b_word2 valid=%b word=%b busy=%b exp 1 1101 1", valid_1, word_1, busy_1);
    else pass_cnt++;
    cont = 0;
    step();
    total_cnt++;
    if (busy_1 !== 1'b0 || valid_1 !== 1'b0)
      $display("FAIL b2b_stop busy=%b valid=%b exp 0 0", busy_1, valid_1);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    a = 0; b = 1; c = 0; d = 1; word_ready = 1; cont = 0;
    start1 = 1;
    step();
    start1 = 0;
    step();
    step();
    total_cnt++;
    if ({s1_1, s2_1} !== 2'b10)
      $display("FAIL areset_pre sel=%b exp 10", {s1_1, s2_1});
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({s1_1, s2_1, busy_1, valid_1, word_1} !== 8'h00)
      $display("FAIL areset_immediate got=%b exp=00000000", {s1_1, s2_1, busy_1, valid_1, word_1});
    else pass_cnt++;
    #1 rst_n = 1'b1;
    step();
    step();
    step();
    total_cnt++;
    if (valid_1 !== 1'b0 || busy_1 !== 1'b0)
      $display("FAIL areset_no_word valid=%b busy=%b exp 0 0", valid_1, busy_1);
    else pass_cnt++;
    start1 = 1;
    step();
    start1 = 0;
    repeat (4) step();
    total_cnt++;
    if (valid_1 !== 1'b1 || word_1 !== 4'b1010)
      $display("FAIL areset_rescan valid=%b word=%b exp 1 1010", valid_1, word_1);
    else pass_cnt++;
    step();
  endtask

  task automatic test_start_held();
    a = 1; b = 0; c = 0; d = 1; word_ready = 1; cont = 0;
    start1 = 1;
    for (int k = 0; k < 12; k++) begin
      step();
      total_cnt++;
      if (busy_1 !== (k % 6 != 5) || valid_1 !== (k % 6 == 4) || {s1_1, s2_1} !== 2'((k % 6 == 5) ? 0 : (k % 6 > 3 ? 3 : k % 6)))
        $display("FAIL start_held k=%0d busy=%b valid=%b sel=%b exp busy=%b valid=%b",
                 k, busy_1, valid_1, {s1_1, s2_1}, (k % 6 != 5), (k % 6 == 4));
      else pass_cnt++;
    end
    start1 = 0;
    total_cnt++;
    if (word_1 !== 4'b1001)
      $display("FAIL start_held_word word=%b exp 1001", word_1);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_settle3();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_start_held();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
Upstream and downstream companion to the 1-bit 4:1 mux (inputs a/b/c/d, selects s1/s2, output e).
- Drives the mux selects s1/s2 through channels 0..3 in order.
- Waits a programmable settle time on each channel, then samples e.
- Assembles the four samples into a 4-bit word and presents it on a valid/ready handshake.
- Used to scan four 1-bit sources through a single mux output into one parallel status word.

Parameters:
SETTLE_CYC, 1, cycles each select value is held before e is sampled; legal range 1..15
CNT_W, 4, width of the settle counter; must satisfy 2**CNT_W > SETTLE_CYC

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a scan; honoured only in IDLE
cont  input  1  continuous mode; sampled at handshake completion
e  input  1  mux output being scanned
s1  output  1  mux select MSB (registered)
s2  output  1  mux select LSB (registered)
busy  output  1  high from scan start until word handshake completes
word_out  output  4  scanned word; bit i = e sampled while {s1,s2}==i (bit0=a, bit1=b, bit2=c, bit3=d)
word_valid  output  1  word_out valid; held until accepted
word_ready  input  1  consumer accepts word when word_valid && word_ready on a clock edge

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). While rst_n=0, all of the following are forced immediately, regardless of clk:
  - state=IDLE
  - s1=0, s2=0, busy=0, word_valid=0
  - word_out=4'b0000, settle counter=0, channel index=0
- States:
  - IDLE → SCAN on start=1; that edge sets idx=0, {s1,s2}=2'b00, cnt=0, busy=1.
  - SCAN: cnt increments each cycle.
    - When cnt==SETTLE_CYC-1, the edge captures e into the shadow bit [idx] and resets cnt to 0.
    - If idx<3: idx++ and {s1,s2}=idx+1 on the same edge.
    - If idx==3: go to HOLD; word_out is loaded from the shadow bits 2:0 plus the captured bit3, and word_valid=1. {s1,s2} remains 2'b11.
  - HOLD: word_out and word_valid are stable until word_valid && word_ready. On the handshake edge, word_valid=0 and:
    - cont=1: restart scan as from start (idx=0, sel=00, cnt=0); busy stays 1.
    - cont=0: go to IDLE, busy=0, {s1,s2}=00.
- Latency with no backpressure: start edge → word_valid high after exactly 4*SETTLE_CYC further edges. Default: 4 cycles.
- Select changes only on the capture edge. e is never sampled in the same cycle the select changed (SETTLE_CYC≥1 guarantees this).
- start while busy=1 (SCAN or HOLD) is ignored, not queued.
- start and word_ready both high in HOLD: the handshake completes and start is ignored. A new scan begins only via cont=1 or a later start in IDLE.
- word_ready high while word_valid=0: no effect.
- word_out keeps its last value after handshake until the next HOLD entry. It never shows partial scans.
- rst_n asserted mid-scan or in HOLD: the word is discarded and all outputs take their reset values at once. After release, the block waits in IDLE for start.
- Counter width arithmetic: the comparison is against SETTLE_CYC-1 truncated to CNT_W. Elaboration fails (generate-time check) if SETTLE_CYC<1 or SETTLE_CYC ≥ 2**CNT_W.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE=2'd0, SCAN=2'd1, HOLD=2'd2)
  - constant NUM_CH=4
  - constant SEL_W=2
- One natural sub-module: mux_settle_timer. It holds the settle counter; inputs clear/enable; output is a done pulse when cnt==SETTLE_CYC-1.
- Everything else stays in the top FSM. Bench instantiates the mux and this block together, wired as e → e and s1/s2 → selects.

Test Plan:
1. a=0,b=1,c=0,d=1, SETTLE_CYC=1, pulse start, word_ready=1 → select sequence 00,01,10,11 on consecutive cycles; word_valid on the 4th edge after start; word_out=4'b1010; busy falls on the handshake edge.
2. Same inputs, SETTLE_CYC=3 → each select value held 3 cycles; word_valid 12 edges after start; word_out=4'b1010.
3. a=1,b=1,c=0,d=0, word_ready=0 for 5 cycles after word_valid, start pulsed during HOLD → word_out=4'b0011 stable all 5 cycles; start ignored; after ready, IDLE with busy=0.
4. cont=1, word_ready=1, inputs flipped to a=1,b=0,c=1,d=1 after the first word → back-to-back words 4'b1010 then 4'b1101; busy never drops; select returns to 00 on the cycle after the handshake.
5. rst_n pulsed low asynchronously (mid-cycle) while {s1,s2}=2'b10 in SCAN → s1,s2,busy,word_valid,word_out go to 0 immediately; no word emitted; a new start yields a full 4-channel scan.
6. start held high continuously with cont=0 → a new scan begins on each IDLE cycle only; no start is accepted during SCAN or HOLD.
